// File: rtl/elmnt_wise_div_seq_if.sv
// Handshake and lane bus for the time-shared element-wise Q-format divider.
// Every lane vector packs lane g at [(g+1)*WIDTH-1 : g*WIDTH].
interface elmnt_wise_div_seq_if #(
   parameter int WIDTH = 32,
   parameter int N_REG = 31
);
   logic                         start;
   logic [N_REG-1:0][WIDTH-1:0]  all_a;
   logic [N_REG-1:0][WIDTH-1:0]  all_w;
   logic                         busy;
   logic                         done;
   logic [N_REG-1:0][WIDTH-1:0]  all_div;
   logic [N_REG-1:0]             dz_flags;
   logic [N_REG-1:0]             ovf_flags;

   modport master (
      output start, all_a, all_w,
      input  busy, done, all_div, dz_flags, ovf_flags
   );

   modport slave (
      input  start, all_a, all_w,
      output busy, done, all_div, dz_flags, ovf_flags
   );
endinterface

// File: rtl/elmnt_wise_div_seq.sv
// Element-wise signed Q(WIDTH,FBITS) divider: all_div[g] = all_a[g] / all_w[g].
// A single restoring divider walks the lanes one after another
// (LOAD, WIDTH+FBITS ITER cycles, STORE per lane), so latency is fixed
// at N_REG*(WIDTH+FBITS+2) cycles regardless of the operands.
module elmnt_wise_div_seq #(
   parameter int WIDTH = 32,
   parameter int FBITS = 24,
   parameter int N_REG = 31
) (
   input  logic                 clk,
   input  logic                 rst_n,
   elmnt_wise_div_seq_if.slave  bus
);
   localparam int QW = WIDTH + FBITS;
   localparam int LW = (N_REG > 1) ? $clog2(N_REG) : 1;
   localparam int IW = $clog2(QW);

   // Saturation limits expressed on the full-width quotient magnitude.
   localparam logic [QW-1:0]    QMAXP = {{(FBITS+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [QW-1:0]    QMINN = {{FBITS{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] RMAX  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] RMIN  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_STORE, S_DONE} state_t;

   state_t                       state, state_nx;
   logic [N_REG-1:0][WIDTH-1:0]  op_a, op_w;
   logic [LW-1:0]                lane;
   logic [IW-1:0]                it_cnt;
   logic [WIDTH-1:0]             rem;      // partial remainder, always < divisor
   logic [QW-1:0]                dvd;      // dividend shifted out MSB first
   logic [QW-1:0]                quo;
   logic [WIDTH-1:0]             dvs;
   logic                         res_neg, a_neg, w_zero;

   logic [WIDTH-1:0]             cur_a, cur_w, mag_a, mag_w;
   logic [WIDTH:0]               trial, diff;
   logic                         ge;
   logic [WIDTH-1:0]             res;
   logic                         dz_set, ovf_set;
   logic                         last_iter, last_lane;

   assign last_iter = (it_cnt == IW'(QW-1));
   assign last_lane = (lane == LW'(N_REG-1));
   assign bus.busy  = (state != S_IDLE);
   assign bus.done  = (state == S_DONE);

   // Operand select and magnitudes; the most negative value maps to 2^(WIDTH-1).
   always_comb begin
      cur_a = op_a[lane];
      cur_w = op_w[lane];
      mag_a = cur_a[WIDTH-1] ? (~cur_a + WIDTH'(1)) : cur_a;
      mag_w = cur_w[WIDTH-1] ? (~cur_w + WIDTH'(1)) : cur_w;
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      trial = {rem, dvd[QW-1]};
      diff  = trial - {1'b0, dvs};
      ge    = (trial >= {1'b0, dvs});
   end

   // Lane result with divide-by-zero and overflow saturation, in priority order.
   always_comb begin
      res     = '0;
      dz_set  = 1'b0;
      ovf_set = 1'b0;
      if (w_zero) begin
         res    = a_neg ? RMIN : RMAX;
         dz_set = 1'b1;
      end else if (!res_neg && (quo > QMAXP)) begin
         res     = RMAX;
         ovf_set = 1'b1;
      end else if (res_neg && (quo > QMINN)) begin
         res     = RMIN;
         ovf_set = 1'b1;
      end else begin
         // Negating a zero magnitude yields zero, so -0 never appears.
         res = res_neg ? (~quo[WIDTH-1:0] + WIDTH'(1)) : quo[WIDTH-1:0];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.start) state_nx = S_LOAD;
         S_LOAD:  state_nx = S_ITER;
         S_ITER:  if (last_iter) state_nx = S_STORE;
         S_STORE: state_nx = last_lane ? S_DONE : S_LOAD;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Operand capture, divider datapath and per-lane result write-back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a          <= '0;
         op_w          <= '0;
         lane          <= '0;
         it_cnt        <= '0;
         rem           <= '0;
         dvd           <= '0;
         quo           <= '0;
         dvs           <= '0;
         res_neg       <= 1'b0;
         a_neg         <= 1'b0;
         w_zero        <= 1'b0;
         bus.all_div   <= '0;
         bus.dz_flags  <= '0;
         bus.ovf_flags <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  op_a          <= bus.all_a;
                  op_w          <= bus.all_w;
                  lane          <= '0;
                  bus.dz_flags  <= '0;
                  bus.ovf_flags <= '0;
               end
            end
            S_LOAD: begin
               dvd     <= {mag_a, {FBITS{1'b0}}};
               dvs     <= mag_w;
               rem     <= '0;
               quo     <= '0;
               it_cnt  <= '0;
               res_neg <= cur_a[WIDTH-1] ^ cur_w[WIDTH-1];
               a_neg   <= cur_a[WIDTH-1];
               w_zero  <= (cur_w == '0);
            end
            S_ITER: begin
               rem    <= ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
               dvd    <= {dvd[QW-2:0], 1'b0};
               quo    <= {quo[QW-2:0], ge};
               it_cnt <= it_cnt + IW'(1);
            end
            S_STORE: begin
               bus.all_div[lane]   <= res;
               bus.dz_flags[lane]  <= dz_set;
               bus.ovf_flags[lane] <= ovf_set;
               if (!last_lane) lane <= lane + LW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_elmnt_wise_div_seq.sv
// Directed bench for elmnt_wise_div_seq: a table of hand-computed lane
// vectors plus sequences for latency, handshake and mid-run reset.
module tb_elmnt_wise_div_seq;
   localparam int W = 32;
   localparam int F = 24;
   localparam int N = 31;
   localparam int NV = 16;
   localparam int LAT = N * (W + F + 2);   // 1798

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] w;
      logic [W-1:0] q;
      bit           dz;
      bit           ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   vec_t tbl [NV];

   elmnt_wise_div_seq_if #(.WIDTH(W), .N_REG(N)) bus ();

   elmnt_wise_div_seq #(.WIDTH(W), .FBITS(F), .N_REG(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Lane 0 = 6.0/2.0, all other lanes 0/1.0.
   task automatic load_simple();
      for (int g = 0; g < N; g++) begin
         bus.all_a[g] = 32'h0000_0000;
         bus.all_w[g] = 32'h0100_0000;
      end
      bus.all_a[0] = 32'h0600_0000;
      bus.all_w[0] = 32'h0200_0000;
   endtask

   task automatic load_table();
      for (int g = 0; g < N; g++) begin
         if (g < NV) begin
            bus.all_a[g] = tbl[g].a;
            bus.all_w[g] = tbl[g].w;
         end else begin
            bus.all_a[g] = 32'h0000_0000;
            bus.all_w[g] = 32'h0100_0000;
         end
      end
   endtask

   task automatic check_simple(input string tag);
      chk({tag, "_lane0"}, bus.all_div[0], 32'h0300_0000);
      for (int g = 1; g < N; g++)
         chk($sformatf("%s_lane%0d", tag, g), bus.all_div[g], 32'h0);
      chk({tag, "_dz"}, 32'(bus.dz_flags), 32'h0);
      chk({tag, "_ovf"}, 32'(bus.ovf_flags), 32'h0);
   endtask

   task automatic check_table(input string tag);
      logic [W-1:0] eq;
      logic [1:0]   ef;
      for (int g = 0; g < N; g++) begin
         eq = (g < NV) ? tbl[g].q : 32'h0;
         ef = (g < NV) ? {tbl[g].dz, tbl[g].ovf} : 2'b00;
         chk($sformatf("%s_div%0d", tag, g), bus.all_div[g], eq);
         chk($sformatf("%s_flg%0d", tag, g), 32'({bus.dz_flags[g], bus.ovf_flags[g]}), 32'(ef));
      end
   endtask

   // Start one operation from IDLE and wait (bounded) for done.
   task automatic run_op(input bit glitch, input bit extra, output int lat);
      int cnt;
      bit seen;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("busy_rise", 32'(bus.busy), 32'h1);
      if (glitch) begin
         bus.all_a = ~bus.all_a;
         bus.all_w = ~bus.all_w;
      end
      cnt = 0;
      seen = 1'b0;
      while (!seen && cnt < 4000) begin
         @(posedge clk); #1;
         cnt++;
         if (extra && cnt == 10) bus.start = 1'b1;
         if (extra && cnt == 11) bus.start = 1'b0;
         if (bus.done) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'h1);
      lat = cnt;
      chk("busy_in_done", 32'(bus.busy), 32'h1);
      if (extra) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("done_one_cycle", 32'(bus.done), 32'h0);
      chk("busy_fall", 32'(bus.busy), 32'h0);
      if (extra) begin
         for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("no_extra_op", 32'(bus.done | bus.busy), 32'h0);
         end
      end
   endtask

   initial begin
      int lat;
      tbl[0]  = '{32'h0100_0000, 32'h0300_0000, 32'h0055_5555, 1'b0, 1'b0};
      tbl[1]  = '{32'hFF00_0000, 32'h0300_0000, 32'hFFAA_AAAB, 1'b0, 1'b0};
      tbl[2]  = '{32'hFF00_0000, 32'h0400_0000, 32'hFFC0_0000, 1'b0, 1'b0};
      tbl[3]  = '{32'hFE00_0000, 32'hFE00_0000, 32'h0100_0000, 1'b0, 1'b0};
      tbl[4]  = '{32'h0500_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
      tbl[5]  = '{32'hFB00_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0};
      tbl[6]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
      tbl[7]  = '{32'h6400_0000, 32'h0080_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
      tbl[8]  = '{32'h9C00_0000, 32'h0080_0000, 32'h8000_0000, 1'b0, 1'b1};
      tbl[9]  = '{32'h8000_0000, 32'h0100_0000, 32'h8000_0000, 1'b0, 1'b0};
      tbl[10] = '{32'h0600_0000, 32'h0200_0000, 32'h0300_0000, 1'b0, 1'b0};
      tbl[11] = '{32'h0780_0000, 32'h0280_0000, 32'h0300_0000, 1'b0, 1'b0};
      tbl[12] = '{32'h0000_0000, 32'hFF00_0000, 32'h0000_0000, 1'b0, 1'b0};
      tbl[13] = '{32'h0000_0001, 32'h0100_0000, 32'h0000_0001, 1'b0, 1'b0};
      tbl[14] = '{32'h0100_0000, 32'hFD00_0000, 32'hFFAA_AAAB, 1'b0, 1'b0};
      tbl[15] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0100_0000, 1'b0, 1'b0};

      bus.start = 1'b0;
      bus.all_a = '0;
      bus.all_w = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_div", 32'(|bus.all_div), 32'h0);
      chk("rst_dz", 32'(bus.dz_flags), 32'h0);
      chk("rst_ovf", 32'(bus.ovf_flags), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic lane 0 divide and latency.
      load_simple();
      run_op(1'b0, 1'b0, lat);
      chk("t1_latency", 32'(lat), 32'(LAT));
      check_simple("t1");

      // Table vectors, with inputs scrambled after capture and ignored starts.
      load_table();
      run_op(1'b1, 1'b1, lat);
      chk("t2_latency", 32'(lat), 32'(LAT));
      check_table("t2");

      // Reset around cycle 500 of an operation: outputs clear without an edge.
      load_simple();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (499) @(posedge clk);
      #1;
      chk("pre_rst_busy", 32'(bus.busy), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus.busy), 32'h0);
      chk("mid_rst_done", 32'(bus.done), 32'h0);
      chk("mid_rst_div", 32'(|bus.all_div), 32'h0);
      chk("mid_rst_dz", 32'(bus.dz_flags), 32'h0);
      chk("mid_rst_ovf", 32'(bus.ovf_flags), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Recovery after reset.
      load_table();
      run_op(1'b0, 1'b0, lat);
      chk("t6_latency", 32'(lat), 32'(LAT));
      check_table("t6");

      // Second start from IDLE clears the flags left by the table run.
      load_simple();
      run_op(1'b0, 1'b0, lat);
      chk("t5_latency", 32'(lat), 32'(LAT));
      check_simple("t5");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
